nios2_oci_dct_monitor: RTL and testbench

- Parametrised successor to the Nios II OCI debug-capture-trace (DCT) test-bench hook.
- Captures DCT frames (packed buffer plus valid-entry count) into an internal FIFO and exposes them on a valid/ready stream.
- Maintains frame and drop statistics and runs an end-of-test drain handshake (test_ending in, test_has_ended out).
- Sits beside the OCI trace logic in simulation and debug builds; synthesisable.

---
 rtl/nios2_oci_dct_pkg.sv | 12 +
 rtl/nios2_oci_dct_fifo.sv | 41 ++++
 rtl/nios2_oci_dct_monitor.sv | 95 +++++++++
 tb/tb_nios2_oci_dct_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// nios2_oci_dct_pkg: shared widths, FSM states and saturating increment for the DCT monitor
package nios2_oci_dct_pkg;
  localparam int FRAME_W_DEF = 30;
  localparam int COUNT_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_e;
  // Saturates at 2^w-1 for any w up to 32; callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v >= m) ? m : v + 32'd1;
  endfunction
endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// nios2_oci_dct_fifo: first-word-fall-through FIFO; push ignored when full, pop ignored when empty
module nios2_oci_dct_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          wr, rd;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign level_o = level_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wr ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= rd ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_q + LW'(wr) - LW'(rd);
    end
  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= din_i;
endmodule

// File: rtl/nios2_oci_dct_monitor.sv
// nios2_oci_dct_monitor: captures DCT frames into a FIFO stream with stats and end-of-test drain.
// Optional illegal-count check enabled by defining NIOS2_OCI_DCT_CHECK_EN.
module nios2_oci_dct_monitor
  import nios2_oci_dct_pkg::*;
#(
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int DEPTH     = 16,
  parameter int STAT_W    = 16,
  parameter int MAX_COUNT = 15,
  localparam int LW       = $clog2(DEPTH) + 1,
  localparam int DW       = COUNT_W + FRAME_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               capture_en,
  input  logic               dct_valid,
  input  logic [FRAME_W-1:0] dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               test_ending,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [LW-1:0]      fifo_level,
  output logic [STAT_W-1:0]  frame_count,
  output logic [STAT_W-1:0]  drop_count,
  output logic               busy,
  output logic               test_has_ended,
  output logic               check_err
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_COUNT < 1 || STAT_W > 32) begin : g_bad_param
    $error("nios2_oci_dct_monitor: illegal parameter set");
  end
  state_e              state_q, state_d;
  logic [STAT_W-1:0]   frame_q, frame_d, drop_q, drop_d;
  logic                ended_q;
  logic                full, empty, presented, push, drop, pop, drained;
  assign presented = state_q == CAPTURE && dct_valid && dct_count != '0;
  // Full is the pre-pop view, so a same-cycle pop never rescues a frame.
  assign push      = presented && !full;
  assign drop      = presented && full;
  assign pop       = out_valid && out_ready;
  assign drained   = fifo_level == '0 || (fifo_level == LW'(1) && pop);
  nios2_oci_dct_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   ({dct_count, dct_buffer}),
    .pop_i   (pop),
    .dout_o  (out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  always_comb begin
    state_d = state_q;
    frame_d = push ? STAT_W'(sat_inc(32'(frame_q), STAT_W)) : frame_q;
    drop_d  = drop ? STAT_W'(sat_inc(32'(drop_q), STAT_W)) : drop_q;
    case (state_q)
      IDLE:    state_d = test_ending ? DRAIN : capture_en ? CAPTURE : IDLE;
      CAPTURE: state_d = test_ending ? DRAIN : CAPTURE;
      DRAIN:   state_d = drained ? DONE : DRAIN;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      drop_q  <= '0;
      ended_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      ended_q <= state_d == DONE;
    end
  assign out_valid      = !empty;
  assign frame_count    = frame_q;
  assign drop_count     = drop_q;
  assign busy           = state_q == CAPTURE || state_q == DRAIN;
  assign test_has_ended = ended_q;
`ifdef NIOS2_OCI_DCT_CHECK_EN
  logic err_q, over;
  assign over = dct_valid && 32'(dct_count) > 32'(MAX_COUNT);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else if (over) err_q <= 1'b1;
  always_ff @(posedge clk)
    assert (!(reset_n && over)) else $error("dct_count %0d exceeds MAX_COUNT %0d", dct_count, MAX_COUNT);
  assign check_err = err_q;
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// tb_nios2_oci_dct_monitor: directed stimulus with a queue scoreboard checked by a pop monitor
module tb_nios2_oci_dct_monitor;
  localparam int FRAME_W = 30, COUNT_W = 4, DEPTH = 16, STAT_W = 16;
  localparam int DW = COUNT_W + FRAME_W, LW = $clog2(DEPTH) + 1;
  logic               clk = 1'b0, reset_n, capture_en, dct_valid, test_ending, out_ready;
  logic [FRAME_W-1:0] dct_buffer;
  logic [COUNT_W-1:0] dct_count;
  logic               out_valid, busy, test_has_ended, check_err;
  logic [DW-1:0]      out_data;
  logic [LW-1:0]      fifo_level;
  logic [STAT_W-1:0]  frame_count, drop_count;
  logic [DW-1:0]      sb[$];
  int                 checks = 0, errors = 0;
  nios2_oci_dct_monitor #(
    .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .STAT_W(STAT_W), .MAX_COUNT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .frame_count(frame_count), .drop_count(drop_count),
    .busy(busy), .test_has_ended(test_has_ended), .check_err(check_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h, no frame expected", out_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [COUNT_W-1:0] c, input logic [FRAME_W-1:0] b, input bit stored);
    dct_valid  = 1'b1;
    dct_count  = c;
    dct_buffer = b;
    if (stored) sb.push_back({c, b});
  endtask
  initial begin
    int n;
    reset_n = 1'b0; capture_en = 1'b0; dct_valid = 1'b0; test_ending = 1'b0; out_ready = 1'b0;
    dct_buffer = '0; dct_count = '0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ended", test_has_ended, 0);
    chk("rst_check_err", check_err, 0);
    reset_n = 1'b1;
    step();
    frame(4'd3, 30'hAAA, 0);
    step(); step();
    chk("idle_level", fifo_level, 0);
    chk("idle_frames", frame_count, 0);
    chk("idle_busy", busy, 0);
    dct_valid = 1'b0; capture_en = 1'b1;
    step();
    chk("capture_busy", busy, 1);
    frame(4'd0, 30'h55, 0);
    step();
    dct_valid = 1'b0;
    step();
    chk("zero_cnt_level", fifo_level, 0);
    chk("zero_cnt_frames", frame_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame(4'd3, 30'h1234567, 1);
      step();
      chk("fwft_valid", out_valid, 1);
    end
    dct_valid = 1'b0;
    step();
    chk("t1_frames", frame_count, 3);
    chk("t1_level", fifo_level, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      frame(COUNT_W'(i % 10 + 1), FRAME_W'(i + 1), i < DEPTH);
      step();
    end
    chk("full_level", fifo_level, 16);
    chk("full_frames", frame_count, 19);
    chk("full_drops", drop_count, 4);
    out_ready = 1'b1;
    frame(4'd7, 30'h3FFFFFFF, 0);
    step();
    dct_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_level", fifo_level, 15);
    chk("pushpop_drops", drop_count, 5);
    chk("pushpop_frames", frame_count, 19);
    out_ready = 1'b1;
    repeat (15) step();
    out_ready = 1'b0;
    chk("emptied_level", fifo_level, 0);
    for (int i = 0; i < 5; i++) begin
      frame(4'd2, FRAME_W'(32'h100 + i), 1);
      step();
    end
    frame(4'd9, 30'h2ABCDEF, 1);
    test_ending = 1'b1;
    step();
    dct_valid = 1'b0; test_ending = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_level", fifo_level, 6);
    chk("drain_frames", frame_count, 25);
    chk("drain_ended", test_has_ended, 0);
    out_ready = 1'b1;
    n = 0;
    while (fifo_level != 0 && n < 40) begin
      chk("ended_early", test_has_ended, 0);
      step();
      n++;
    end
    chk("drain_cycles", n, 6);
    chk("ended_at_empty", test_has_ended, 1);
    chk("done_busy", busy, 0);
    chk("sb_drained", sb.size(), 0);
    out_ready = 1'b0;
    frame(4'd4, 30'h9, 0);
    step(); step();
    dct_valid = 1'b0;
    chk("done_level", fifo_level, 0);
    chk("done_frames", frame_count, 25);
    chk("done_drops", drop_count, 5);
    chk("done_sticky", test_has_ended, 1);
    reset_n = 1'b0;
    sb.delete();
    step();
    reset_n = 1'b1; capture_en = 1'b1;
    step();
    frame(4'd12, 30'hC0FFEE, 1);
    step();
    dct_valid = 1'b0;
`ifdef NIOS2_OCI_DCT_CHECK_EN
    chk("check_err_set", check_err, 1);
`else
    chk("check_err_off", check_err, 0);
`endif
    chk("big_cnt_level", fifo_level, 1);
    chk("big_cnt_frames", frame_count, 1);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_frames", frame_count, 0);
    chk("arst_drops", drop_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ended", test_has_ended, 0);
    chk("arst_check_err", check_err, 0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
